// File: rtl/bit_index_serializer.sv
// -----------------------------------------------------------------------------
// bit_index_serializer
//
// Zero-skipping scheduler for bit-serial compute. A DATA_WIDTH-bit operand is
// accepted on the input side. The block then emits the index of each set
// ("essential") bit, one per output beat, starting from the MSB. Zero bits
// produce no beats.
//
// Index convention: idx 0 = in_data[DATA_WIDTH-1], idx DATA_WIDTH-1 = in_data[0].
// out_idx feeds a one-hot decoder directly. The decoder's valid input is
// out_val & out_rdy.
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid & ready are both 1.
//   While out_val=1 and out_rdy=0, out_val, out_idx, out_last and out_trunc
//   are held constant. out_val depends only on registered state. The only
//   combinational input-to-output path is out_rdy -> in_rdy, which lets a new
//   word load in the same cycle as the last beat of the previous word.
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous, active-high
//   in_data    in   DATA_WIDTH  operand word
//   in_val     in   1           in_data valid
//   in_rdy     out  1           a word can be accepted this cycle
//   out_idx    out  IDX_WIDTH   index of the current essential bit (0 when idle)
//   out_val    out  1           out_idx valid
//   out_rdy    in   1           downstream accepts the beat
//   out_last   out  1           current beat is the final beat of its word
//   out_trunc  out  1           with out_last: set bits were dropped at MAX_BITS
// -----------------------------------------------------------------------------
module bit_index_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(DATA_WIDTH),
    parameter int MAX_BITS   = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic                  out_last,
    output logic                  out_trunc
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] res;   // set bits of the current word not yet emitted
    logic [IDX_WIDTH:0]    cnt;   // beats already emitted for the current word

    logic [IDX_WIDTH-1:0]  lead_idx;
    logic [DATA_WIDTH-1:0] lead_mask;
    logic                  multi_c;
    logic                  last_c;
    logic                  in_xfer;
    logic                  out_beat;

    // Priority encoder on the registered residual word. Positions are scanned
    // from low to high, so the highest set bit is written last and wins.
    // lead_mask is the one-hot of that bit and is used to clear it after a beat.
    always_comb begin
        lead_idx  = '0;
        lead_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (res[i]) begin
                lead_idx     = IDX_WIDTH'(DATA_WIDTH - 1 - i);
                lead_mask    = '0;
                lead_mask[i] = 1'b1;
            end
        end
    end

    // x & (x-1) clears the lowest set bit. A nonzero result means two or more
    // bits are set.
    assign multi_c = |(res & (res - DATA_WIDTH'(1)));

    // The word ends when one set bit remains or when the beat budget is used up.
    assign last_c = !multi_c || (cnt == (IDX_WIDTH + 1)'(MAX_BITS - 1));

    assign out_val   = (state == SCAN);
    assign out_idx   = out_val ? lead_idx : '0;
    assign out_last  = out_val && last_c;
    assign out_trunc = out_val && last_c && multi_c;

    // A new word may load while the final beat of the previous word is taken.
    assign in_rdy   = (state == IDLE) || ((state == SCAN) && out_rdy && last_c);
    assign in_xfer  = in_val && in_rdy;
    assign out_beat = out_val && out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            res   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // An all-zero word is consumed without producing any beats.
                    if (in_xfer && (in_data != '0)) begin
                        res   <= in_data;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_beat) begin
                        if (!last_c) begin
                            res <= res & ~lead_mask;
                            cnt <= cnt + 1'b1;
                        end else if (in_xfer && (in_data != '0)) begin
                            // Back-to-back: the next word starts with no bubble.
                            res <= in_data;
                            cnt <= '0;
                        end else begin
                            res   <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    res   <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
